// File: rtl/ycolumn_loader.sv
// Configuration loader for one column of yellow cells: serialises host codes onto the
// column's config chain with a registered strobe and collects the displaced bits as readback.
module ycolumn_loader #(
  parameter int CELLS = 8,
  parameter int CODEW = 3
) (
  input  logic                     confclk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     code_valid,
  input  logic [CODEW-1:0]         code_in,
  output logic                     code_ready,
  output logic                     cbit,
  output logic                     colclk,
  input  logic                     chain_in,
  output logic                     cell_reset,
  output logic                     busy,
  output logic                     done,
  output logic [CODEW*CELLS-1:0]   rb_data
);

  localparam int RBW = CODEW * CELLS;
  localparam int BCW = (CODEW > 1) ? $clog2(CODEW) : 1;
  localparam int CCW = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SHA,
    S_SHB,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CODEW-1:0] r_shreg;
  logic [CODEW-1:0] w_shreg_nxt;
  logic [BCW-1:0]   r_bitcnt;
  logic [CCW-1:0]   r_cellcnt;
  logic             r_hold;
  logic             r_cbit;
  logic             r_colclk;
  logic             r_code_ready;
  logic             r_busy;
  logic             r_done;
  logic [RBW-1:0]   r_rb;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_last_cell;

  assign w_accept    = r_code_ready & code_valid;
  assign w_last_bit  = (r_bitcnt == BCW'(CODEW - 1));
  assign w_last_cell = (r_cellcnt == CCW'(CELLS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_FETCH;
      S_FETCH: begin
        if (w_accept) begin
          w_state_nxt = S_SHA;
          w_shreg_nxt = code_in;
        end
      end
      S_SHA:   w_state_nxt = S_SHB;
      S_SHB: begin
        w_shreg_nxt = r_shreg << 1;
        if (w_last_bit) w_state_nxt = w_last_cell ? S_DONE : S_FETCH;
        else            w_state_nxt = S_SHA;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Payload register carries no control meaning, so it is left out of reset.
  always_ff @(posedge confclk) begin
    r_shreg <= w_shreg_nxt;
  end

  // Outputs are decoded from the next state so they are registered yet line up with r_state.
  always_ff @(posedge confclk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_bitcnt     <= '0;
      r_cellcnt    <= '0;
      r_hold       <= 1'b0;
      r_cbit       <= 1'b0;
      r_colclk     <= 1'b0;
      r_code_ready <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_rb         <= '0;
    end else begin
      r_state <= w_state_nxt;

      if (r_state == S_FETCH && w_accept)
        r_bitcnt <= '0;
      else if (r_state == S_SHB && !w_last_bit)
        r_bitcnt <= r_bitcnt + BCW'(1);

      if (r_state == S_IDLE && start)
        r_cellcnt <= '0;
      else if (r_state == S_SHB && w_last_bit)
        r_cellcnt <= r_cellcnt + CCW'(1);

      if (r_state == S_IDLE && start)
        r_hold <= 1'b1;
      else if (r_state == S_DONE)
        r_hold <= 1'b0;

      if (r_state == S_SHA)
        r_rb <= (r_rb << 1) | RBW'(chain_in);

      // cbit is set up on entry to SHA and held through SHB so it is stable at the strobe.
      if (w_state_nxt == S_SHA)
        r_cbit <= w_shreg_nxt[CODEW-1];
      else if (w_state_nxt == S_IDLE)
        r_cbit <= 1'b0;

      r_colclk     <= (w_state_nxt == S_SHB);
      r_code_ready <= (w_state_nxt == S_FETCH);
      r_busy       <= (w_state_nxt != S_IDLE);
      r_done       <= (w_state_nxt == S_DONE);
    end
  end

  assign cell_reset = reset | r_hold;
  assign code_ready = r_code_ready;
  assign cbit       = r_cbit;
  assign colclk     = r_colclk;
  assign busy       = r_busy;
  assign done       = r_done;
  assign rb_data    = r_rb;

endmodule

// File: tb/tb_ycolumn_loader.sv
// Directed bench for ycolumn_loader with a two-cell column whose config chain is modelled
// as a 6-bit shift register clocked by colclk.
module tb_ycolumn_loader;

  logic       confclk;
  logic       reset;
  logic       start;
  logic       code_valid;
  logic [2:0] code_in;
  logic       code_ready;
  logic       cbit;
  logic       colclk;
  logic       chain_in;
  logic       cell_reset;
  logic       busy;
  logic       done;
  logic [5:0] rb_data;

  int total = 0;
  int bad   = 0;

  ycolumn_loader #(.CELLS(2), .CODEW(3)) dut (
    .confclk    (confclk),
    .reset      (reset),
    .start      (start),
    .code_valid (code_valid),
    .code_in    (code_in),
    .code_ready (code_ready),
    .cbit       (cbit),
    .colclk     (colclk),
    .chain_in   (chain_in),
    .cell_reset (cell_reset),
    .busy       (busy),
    .done       (done),
    .rb_data    (rb_data)
  );

  initial confclk = 1'b0;
  always #5 confclk = ~confclk;

  // Column model {bottom[2:0], top[2:0]}: bits enter the top, leave the bottom MSB.
  logic [5:0] chain_vec = 6'b000000;
  assign chain_in = chain_vec[5];
  always @(posedge colclk) chain_vec <= {chain_vec[4:0], cbit};

  int         strobe_cnt = 0;
  logic [5:0] seq = 6'b0;
  logic       prev_colclk = 1'b0;
  logic       prev_cbit = 1'b0;

  // Strobe monitor: cbit must be unchanged across the rising strobe, strobes one cycle wide.
  always @(negedge confclk) begin
    if (colclk) begin
      total++;
      if (prev_colclk) begin
        bad++;
        $display("FAIL strobe_width: colclk high two cycles (got 1 expected 0 in prior cycle)");
      end else begin
        strobe_cnt++;
        seq = {seq[4:0], cbit};
        total++;
        if (cbit !== prev_cbit) begin
          bad++;
          $display("FAIL cbit_setup: got %0b expected %0b", cbit, prev_cbit);
        end
      end
    end
    prev_colclk = colclk;
    prev_cbit   = cbit;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] a;
    logic [2:0] b;
    int         stall;
    bit         mid_start;
    logic [5:0] exp_rb;
    logic [2:0] exp_bot;
    logic [2:0] exp_top;
    int         exp_lat;
  } vec_t;

  vec_t tbl[4];

  // Runs one load; lat is the cycle count from the start cycle (1) to the done cycle.
  task automatic do_load(input logic [2:0] a, input logic [2:0] b, input int stall,
                         input bit mid_start, output int lat);
    int idx;
    int stall_left;
    int cyc;
    bit pulsed;
    strobe_cnt = 0;
    seq        = 6'b0;
    idx        = 0;
    stall_left = stall;
    cyc        = 1;
    lat        = 0;
    pulsed     = 1'b0;
    @(negedge confclk);
    start      = 1'b1;
    code_valid = 1'b0;
    @(posedge confclk); #1;
    start = 1'b0;
    for (int n = 0; n < 200; n++) begin
      cyc++;
      if (done) begin
        lat = cyc;
        break;
      end
      start = 1'b0;
      if (mid_start && colclk && !pulsed) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      if (code_ready && idx < 2) begin
        if (idx == 1 && stall_left > 0) begin
          code_valid = 1'b0;
          stall_left--;
          chk("stall_cell_reset", 32'(cell_reset), 32'd1);
          chk("stall_colclk", 32'(colclk), 32'd0);
        end else begin
          code_valid = 1'b1;
          code_in    = (idx == 0) ? a : b;
          idx++;
        end
      end else begin
        code_valid = 1'b0;
      end
      @(posedge confclk); #1;
    end
    code_valid = 1'b0;
    start      = 1'b0;
    if (lat == 0) begin
      bad++;
      total++;
      $display("FAIL load_timeout: got no done expected done within 200 cycles");
    end
  endtask

  task automatic check_load(input int idx, input vec_t v, input int lat);
    chk($sformatf("latency[%0d]", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("strobes[%0d]", idx), 32'(strobe_cnt), 32'd6);
    chk($sformatf("cbit_seq[%0d]", idx), 32'(seq), 32'({v.a, v.b}));
    chk($sformatf("rb_data[%0d]", idx), 32'(rb_data), 32'(v.exp_rb));
    chk($sformatf("bottom[%0d]", idx), 32'(chain_vec[5:3]), 32'(v.exp_bot));
    chk($sformatf("top[%0d]", idx), 32'(chain_vec[2:0]), 32'(v.exp_top));
    @(posedge confclk); #1;
    chk($sformatf("done_pulse[%0d]", idx), 32'(done), 32'd0);
    chk($sformatf("idle_busy[%0d]", idx), 32'(busy), 32'd0);
    chk($sformatf("idle_cell_reset[%0d]", idx), 32'(cell_reset), 32'd0);
  endtask

  initial begin
    int   lat;
    int   n;
    vec_t v;

    tbl[0] = '{3'b110, 3'b001, 0, 1'b0, 6'b000000, 3'b110, 3'b001, 16};
    tbl[1] = '{3'b010, 3'b111, 0, 1'b0, 6'b110001, 3'b010, 3'b111, 16};
    tbl[2] = '{3'b000, 3'b101, 5, 1'b0, 6'b010111, 3'b000, 3'b101, 21};
    tbl[3] = '{3'b011, 3'b100, 0, 1'b1, 6'b000101, 3'b011, 3'b100, 16};

    reset      = 1'b1;
    start      = 1'b0;
    code_valid = 1'b0;
    code_in    = 3'b000;
    repeat (3) @(posedge confclk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_colclk", 32'(colclk), 32'd0);
    chk("rst_cbit", 32'(cbit), 32'd0);
    chk("rst_code_ready", 32'(code_ready), 32'd0);
    chk("rst_rb_data", 32'(rb_data), 32'd0);
    chk("rst_cell_reset", 32'(cell_reset), 32'd1);
    @(negedge confclk);
    reset = 1'b0;
    @(posedge confclk); #1;
    chk("post_rst_cell_reset", 32'(cell_reset), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 4; i++) begin
      do_load(tbl[i].a, tbl[i].b, tbl[i].stall, tbl[i].mid_start, lat);
      check_load(i, tbl[i], lat);
    end

    // Reset after three strobes of a load sending 110 first.
    strobe_cnt = 0;
    @(negedge confclk);
    start      = 1'b1;
    code_valid = 1'b1;
    code_in    = 3'b110;
    @(posedge confclk); #1;
    start = 1'b0;
    n = 0;
    while (strobe_cnt < 3 && n < 100) begin
      @(posedge confclk); #1;
      n++;
    end
    chk("midrst_strobes", 32'(strobe_cnt), 32'd3);
    reset = 1'b1;
    #1;
    chk("midrst_colclk", 32'(colclk), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cbit", 32'(cbit), 32'd0);
    chk("midrst_cell_reset", 32'(cell_reset), 32'd1);
    chk("midrst_code_ready", 32'(code_ready), 32'd0);
    code_valid = 1'b0;
    @(negedge confclk);
    reset = 1'b0;
    @(posedge confclk); #1;
    chk("midrst_release_cell_reset", 32'(cell_reset), 32'd0);
    chk("midrst_release_busy", 32'(busy), 32'd0);
    chk("midrst_partial_chain", 32'(chain_vec), 32'(6'b100110));
    @(posedge confclk); #1;
    chk("midrst_no_strobe", 32'(strobe_cnt), 32'd3);

    v = '{3'b101, 3'b010, 0, 1'b0, 6'b100110, 3'b101, 3'b010, 16};
    do_load(v.a, v.b, v.stall, v.mid_start, lat);
    check_load(4, v, lat);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ycolumn_loader.md
Name: ycolumn_loader

Overview:
- Synchronous configuration loader for one column of yellow cells.
- Takes 3-bit cell codes from a host over a valid/ready stream and serialises them onto the column's configuration chain: cbit into the top cell's cbitin, plus a generated strobe into every cell's confclk.
- Holds the column in reset while loading.
- Captures the bits leaving the bottom cell's cbitout, so the previous column configuration is returned as readback.

Parameters:
- CELLS, 8, number of yellow cells in the column (≥1).
- CODEW, 3, configuration bits per cell; fixed by the cell's config register.

Ports:
- confclk  input  1  loader clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; clears all loader state.
- start  input  1  single-cycle request to begin a column load; ignored unless IDLE.
- code_valid  input  1  host has a cell code on code_in.
- code_in  input  CODEW  cell code; codes are sent bottom cell first, top cell last.
- code_ready  output  1  loader accepts code_in this cycle.
- cbit  output  1  serial bit to the top cell's cbitin.
- colclk  output  1  configuration strobe to every cell's confclk in the column.
- chain_in  input  1  bottom cell's cbitout.
- cell_reset  output  1  drives the reset of every cell in the column.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the load completes.
- rb_data  output  CODEW*CELLS  previous configuration as {bottom,...,top} codes.

Behaviour:
- Reset values (asynchronous):
  - state=IDLE; cbit=0, colclk=0, code_ready=0, busy=0, done=0.
  - rb_data=0; bit counter=0, cell counter=0, hold flag=0.
- cell_reset = reset | hold flag. Cells are therefore also held while the loader itself is in reset.
- States:
  - IDLE: start=1 → FETCH. On the same edge, hold flag←1 and the cell counter is cleared.
  - FETCH:
    - code_ready=1.
    - On code_valid&code_ready: latch code_in into the shift register, bit counter←0, go to SHA.
    - Staying in FETCH does not pulse colclk.
  - SHA (bit setup, 1 cycle):
    - cbit = shift register MSB; colclk=0.
    - chain_in is sampled into rb_data's LSB end, with rb_data shifted left by one.
    - → SHB.
  - SHB (strobe, 1 cycle):
    - colclk=1; cbit unchanged. Cells shift on this rising strobe.
    - Shift register shifts left.
    - If bit counter=CODEW-1: increment cell counter; go to DONE if it reaches CELLS, else FETCH.
    - Otherwise: increment bit counter, → SHA.
  - DONE (1 cycle): done=1, colclk=0, hold flag←0 at the exit edge, → IDLE.
- colclk and cbit are driven from registers, so the outputs are glitch-free.
- cbit is stable for the whole SHA+SHB pair and is set up one full cycle before colclk rises.
- Bit order: code MSB first, bottom cell's code first.
  - After CODEW*CELLS strobes, cell i (top=0) holds the (CELLS-1-i)-th code sent.
  - rb_data = {old bottom code, ..., old top code}.
- Latency: with code_valid held high, start to done = 1 + CELLS*(1 + 2*CODEW) + 1 cycles. This is 58 cycles for CELLS=8.
- busy=1 in FETCH, SHA, SHB and DONE.
- rb_data is held stable outside SHA and is valid from the done pulse until the next start.
- Boundary cases:
  - start during a load: ignored.
  - code_valid while not in FETCH: not accepted.
  - Host stalls in FETCH: wait indefinitely with colclk=0 and cell_reset=1.
  - Reset mid-load: everything returns immediately to the reset values. Cells keep a partial configuration, and cell_reset remains asserted only while reset is high.
  - Counters never wrap past CELLS or CODEW.

Test Plan:
- Basic load (CELLS=2, chain modelled by two cell config registers starting at 000):
  - Stimulus: start, send 110 then 001.
  - Required: cbit sequence 1,1,0,0,0,1 on six colclk rising edges.
  - Required: bottom=110, top=001, done pulse 16 cycles after start, rb_data=000000.
- Readback: repeat the load with codes 010 then 111 → rb_data=110001 at done; cells become bottom=010, top=111.
- Host stall: code_valid deasserted for 5 cycles in FETCH.
  - Required: no colclk edges and cell_reset=1 during the stall.
  - Required: done is delayed by exactly 5 cycles.
- Start while busy: a second start pulse mid-SHB → no effect; exactly CODEW*CELLS strobes occur.
- Reset mid-load: assert reset after 3 strobes.
  - Required: colclk=0, busy=0, cbit=0, cell_reset=1 within the same cycle.
  - Required: after release, IDLE with cell_reset=0, and a fresh load completes correctly.
- Setup/hold check: at every colclk rising edge, cbit equals its value in the preceding cycle; colclk is never high in two consecutive cycles.
